// File: rtl/sc_input_hub.sv
// Memory-mapped input hub: synchronized, debounced switches and keys,
// sticky key-press flags, a KEY[0] press counter and a maskable irq.
module sc_input_hub #(
   parameter int         DEBOUNCE_CYCLES = 500000,
   parameter int         CNT_W           = 20,
   parameter logic [7:0] BASE_HI         = 8'hF2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] addr,
   input  logic [31:0] datain,
   input  logic        we,
   output logic [31:0] dataout,
   output logic        hit,
   input  logic [9:0]  SW,
   input  logic [3:0]  KEY,
   output logic        irq
);

   localparam int N = 14;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   logic [N-1:0]     raw;
   logic [N-1:0]     s1;
   logic [N-1:0]     s2;
   logic [N-1:0]     stable;
   logic [N-1:0]     stable_nx;
   logic [CNT_W-1:0] cnt [N];

   logic [3:0]  flags;
   logic [3:0]  flags_nx;
   logic [3:0]  mask;
   logic [3:0]  mask_nx;
   logic [3:0]  press;
   logic [3:0]  clr;
   logic [15:0] cnt16;
   logic [15:0] cnt16_nx;
   logic [3:0]  idx;
   logic        wr;
   logic        wr_flg;
   logic        wr_cnt;
   logic        wr_msk;
   logic        unused;

   // keys are inverted before syncing so pressed reads as 1 internally
   assign raw = {~KEY, SW};
   assign hit = (addr[31:24] == BASE_HI);
   assign idx = addr[5:2];
   assign wr  = we & hit;

   assign wr_flg = wr & (idx == 4'd2);
   assign wr_cnt = wr & (idx == 4'd3);
   assign wr_msk = wr & (idx == 4'd4);

   assign unused = ^{addr[23:6], addr[1:0], datain[31:4]};

   always_comb begin
      for (int i = 0; i < N; i++) begin
         stable_nx[i] = stable[i];
         if ((s2[i] != stable[i]) && (cnt[i] == LAST))
            stable_nx[i] = s2[i];
      end
   end

   assign press = stable_nx[13:10] & ~stable[13:10];
   assign clr   = wr_flg ? datain[3:0] : 4'h0;

   // set beats clear, and a press on a counter write leaves it at 1
   assign flags_nx = (flags & ~clr) | press;
   assign mask_nx  = wr_msk ? datain[3:0] : mask;
   assign cnt16_nx = (wr_cnt ? 16'h0 : cnt16) + {15'd0, press[0]};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1     <= '0;
         s2     <= '0;
         stable <= '0;
         for (int i = 0; i < N; i++)
            cnt[i] <= '0;
      end else begin
         s1     <= raw;
         s2     <= s1;
         stable <= stable_nx;
         for (int i = 0; i < N; i++) begin
            if (s2[i] == stable[i])
               cnt[i] <= '0;
            else if (cnt[i] == LAST)
               cnt[i] <= '0;
            else
               cnt[i] <= cnt[i] + ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         flags <= '0;
         mask  <= '0;
         cnt16 <= '0;
         irq   <= 1'b0;
      end else begin
         flags <= flags_nx;
         mask  <= mask_nx;
         irq   <= |(flags_nx & mask_nx);
         if (wr_cnt | press[0])
            cnt16 <= cnt16_nx;
      end
   end

   always_comb begin
      dataout = '0;
      if (hit) begin
         case (idx)
            4'd0:    dataout = {22'd0, stable[9:0]};
            4'd1:    dataout = {28'd0, stable[13:10]};
            4'd2:    dataout = {28'd0, flags};
            4'd3:    dataout = {16'd0, cnt16};
            4'd4:    dataout = {28'd0, mask};
            default: dataout = '0;
         endcase
      end
   end

endmodule
